ucsbece154a_controller_mc: RTL and testbench
============================================

Name: ucsbece154a_controller_mc

Overview:
- Multicycle RISC-V control unit, successor to the single-cycle controller. Drives the shared-memory multicycle datapath through an FSM, one instruction every 3–5+ cycles.
- Adds a memory ready handshake, a configurable wait timeout, lui, optional bne, and a sticky error state for illegal opcodes.

Parameters:
- TIMEOUT_CYCLES, 15: max consecutive wait cycles on mem_ready_i before ERROR; 0 disables the timeout.
- CNT_W, 4: timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.
- SUPPORT_BNE, 1: 1 decodes funct3=001 on the branch opcode as bne; 0 makes it illegal.

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  synchronous, active-low reset
- op_i  in  7  instruction opcode
- funct3_i  in  3  instruction funct3
- funct7b5_i  in  1  instruction bit 30
- zero_i  in  1  ALU zero flag
- mem_ready_i  in  1  memory completes access this cycle
- PCWrite_o  out  1  PC register enable
- AdrSrc_o  out  1  0 = PC, 1 = ALUOut to memory address
- MemWrite_o  out  1  memory write request
- IRWrite_o  out  1  instruction/OldPC register enable
- RegWrite_o  out  1  register file write
- ResultSrc_o  out  2  00 ALUOut, 01 Data, 10 ALUResult, 11 ImmExt
- ALUSrcA_o  out  2  00 PC, 01 OldPC, 10 rs1
- ALUSrcB_o  out  2  00 rs2, 01 ImmExt, 10 constant 4
- ImmSrc_o  out  3  000 I, 001 S, 010 B, 011 J, 100 U
- ALUControl_o  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- error_o  out  1  sticky error flag
- state_o  out  4  current state encoding, for debug

Behaviour:
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, JAL 10, LUI 11, ERROR 12.
- Reset: when reset_n=0 at a clk edge, state becomes FETCH, timeout counter 0, error_o 0. While reset_n=0, all enables/strobes (PCWrite, MemWrite, IRWrite, RegWrite) are forced 0.
- Outputs are combinational from state plus opcode/funct. Any output not listed for a state is driven 0 (never x).
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10.
  - IRWrite and PCWrite assert only in the cycle mem_ready_i=1; go to DECODE on that cycle, otherwise hold FETCH.
- DECODE: ALUSrcA=01, ALUSrcB=01, ImmSrc=010, add. Next state by opcode:
  - lw/sw → MEMADR
  - R-type → EXECR
  - I-ALU → EXECI
  - branch → BRANCH
  - jal → JAL
  - lui → LUI
  - any other opcode → ERROR
- MEMADR: ALUSrcA=10, ALUSrcB=01, add, ImmSrc=000 (lw) or 001 (sw). Next MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: AdrSrc=1, ResultSrc=00. Hold until mem_ready_i=1, then MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1. Next FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 held every cycle until mem_ready_i=1, then FETCH.
- EXECR / EXECI: ALUSrcA=10, ALUSrcB=00 (R) or 01 (I, ImmSrc=000), ALU decode. Next ALUWB.
- ALU decode by funct3:
  - 000: sub only for R-type with funct7b5=1; otherwise add.
  - 010 → slt; 110 → or; 111 → and.
  - Other funct3 → ERROR instead of ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Next FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00.
  - PCWrite = zero_i for funct3=000; PCWrite = !zero_i for funct3=001 when SUPPORT_BNE=1. Next FETCH.
  - Other funct3 → ERROR with PCWrite=0.
- JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1. Next ALUWB (writes PC+4).
- LUI: ImmSrc=100, ResultSrc=11, RegWrite=1. Next FETCH.
- Timeout counter:
  - Increments each cycle spent in FETCH, MEMREAD or MEMWRITE with mem_ready_i=0; clears on any state change.
  - If TIMEOUT_CYCLES>0 and the counter reaches TIMEOUT_CYCLES with mem_ready_i still 0, next state is ERROR.
  - mem_ready_i=1 on the same cycle takes priority over the timeout.
- ERROR: all strobes 0, error_o=1. Held until reset_n=0.
- Reset mid-operation (e.g. in MEMWRITE): MemWrite drops in that same cycle; FETCH on the next edge.

Optional Feature:
- Macro: UCSBECE154A_CTRL_INSTRET_EN.
- Defined: adds output instret_o [31:0], reset to 0. Increments by 1 on every transition into FETCH from MEMWB, MEMWRITE, ALUWB, BRANCH or LUI (JAL retires via ALUWB). Wraps at 2^32−1 → 0. Never increments in ERROR.
- Undefined: no port, no counter logic.

Test Plan:
- Reset, then lw (op 0000011) with mem_ready_i=1 always → states 0,1,2,3,4,0; RegWrite=1, ResultSrc=01 only in state 4.
- sw with mem_ready_i low for 3 cycles in MEMWRITE → MemWrite=1 for 4 consecutive cycles, then FETCH; no timeout.
- beq with zero_i=1 → PCWrite=1 in BRANCH. bne (funct3 001) with zero_i=1 → PCWrite=0. bne with SUPPORT_BNE=0 → state 12, error_o=1.
- R-type sub (funct3 000, funct7b5=1) → ALUControl=001 in EXECR. I-type addi with funct7b5=1 → ALUControl=000.
- jal then lui → JAL: PCWrite=1, state sequence 10, 8, 0. LUI: ResultSrc=11, ImmSrc=100, RegWrite=1.
- mem_ready_i held 0 in FETCH with TIMEOUT_CYCLES=15 → ERROR after 15 wait cycles, error_o sticky. reset_n=0 one cycle → state 0, error_o=0.

Source files
------------

// File: rtl/ucsbece154a_controller_mc.sv
// Multicycle RISC-V control unit: FSM sequencing of the shared-memory
// datapath with a memory-ready handshake, wait timeout and sticky error.
// Optional retired-instruction counter: define UCSBECE154A_CTRL_INSTRET_EN.
module ucsbece154a_controller_mc #(
   parameter int TIMEOUT_CYCLES = 15,
   parameter int CNT_W          = 4,
   parameter int SUPPORT_BNE    = 1
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [6:0] op_i,
   input  logic [2:0] funct3_i,
   input  logic       funct7b5_i,
   input  logic       zero_i,
   input  logic       mem_ready_i,
   output logic       PCWrite_o,
   output logic       AdrSrc_o,
   output logic       MemWrite_o,
   output logic       IRWrite_o,
   output logic       RegWrite_o,
   output logic [1:0] ResultSrc_o,
   output logic [1:0] ALUSrcA_o,
   output logic [1:0] ALUSrcB_o,
   output logic [2:0] ImmSrc_o,
   output logic [2:0] ALUControl_o,
   output logic       error_o,
   output logic [3:0] state_o
`ifdef UCSBECE154A_CTRL_INSTRET_EN
   ,
   output logic [31:0] instret_o
`endif
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_JAL      = 4'd10,
      S_LUI      = 4'd11,
      S_ERROR    = 4'd12
   } state_t;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BR  = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_LUI = 7'b0110111;

   // Last counter value before the wait limit is exceeded.
   localparam logic [CNT_W-1:0] TO_LAST =
      CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [2:0]        alu_ctl;
   logic              alu_ok;
   logic              timeout;
   logic              wait_st;

   // State and wait-counter registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= S_FETCH;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // ALU operation decode from funct3/funct7b5; sub only for R-type.
   always_comb begin
      alu_ctl = 3'b000;
      alu_ok  = 1'b1;
      case (funct3_i)
         3'b000:  alu_ctl = (state_q == S_EXECR && funct7b5_i) ? 3'b001 : 3'b000;
         3'b010:  alu_ctl = 3'b101;
         3'b110:  alu_ctl = 3'b011;
         3'b111:  alu_ctl = 3'b010;
         default: alu_ok  = 1'b0;
      endcase
   end

   assign timeout = (TIMEOUT_CYCLES > 0) && (cnt_q == TO_LAST) && !mem_ready_i;
   assign wait_st = (state_q == S_FETCH) || (state_q == S_MEMREAD) ||
                    (state_q == S_MEMWRITE);

   // Next-state and datapath control outputs.
   always_comb begin
      state_d      = state_q;
      PCWrite_o    = 1'b0;
      AdrSrc_o     = 1'b0;
      MemWrite_o   = 1'b0;
      IRWrite_o    = 1'b0;
      RegWrite_o   = 1'b0;
      ResultSrc_o  = 2'b00;
      ALUSrcA_o    = 2'b00;
      ALUSrcB_o    = 2'b00;
      ImmSrc_o     = 3'b000;
      ALUControl_o = 3'b000;
      case (state_q)
         S_FETCH: begin
            ALUSrcB_o   = 2'b10;
            ResultSrc_o = 2'b10;
            if (mem_ready_i) begin
               IRWrite_o = 1'b1;
               PCWrite_o = 1'b1;
               state_d   = S_DECODE;
            end else if (timeout) begin
               state_d = S_ERROR;
            end
         end
         S_DECODE: begin
            ALUSrcA_o = 2'b01;
            ALUSrcB_o = 2'b01;
            ImmSrc_o  = 3'b010;
            case (op_i)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_R:         state_d = S_EXECR;
               OP_I:         state_d = S_EXECI;
               OP_BR:        state_d = S_BRANCH;
               OP_JAL:       state_d = S_JAL;
               OP_LUI:       state_d = S_LUI;
               default:      state_d = S_ERROR;
            endcase
         end
         S_MEMADR: begin
            ALUSrcA_o = 2'b10;
            ALUSrcB_o = 2'b01;
            ImmSrc_o  = (op_i == OP_SW) ? 3'b001 : 3'b000;
            state_d   = (op_i == OP_SW) ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            AdrSrc_o = 1'b1;
            if (mem_ready_i)  state_d = S_MEMWB;
            else if (timeout) state_d = S_ERROR;
         end
         S_MEMWB: begin
            ResultSrc_o = 2'b01;
            RegWrite_o  = 1'b1;
            state_d     = S_FETCH;
         end
         S_MEMWRITE: begin
            AdrSrc_o   = 1'b1;
            MemWrite_o = 1'b1;
            if (mem_ready_i)  state_d = S_FETCH;
            else if (timeout) state_d = S_ERROR;
         end
         S_EXECR: begin
            ALUSrcA_o    = 2'b10;
            ALUControl_o = alu_ctl;
            state_d      = alu_ok ? S_ALUWB : S_ERROR;
         end
         S_EXECI: begin
            ALUSrcA_o    = 2'b10;
            ALUSrcB_o    = 2'b01;
            ALUControl_o = alu_ctl;
            state_d      = alu_ok ? S_ALUWB : S_ERROR;
         end
         S_ALUWB: begin
            RegWrite_o = 1'b1;
            state_d    = S_FETCH;
         end
         S_BRANCH: begin
            ALUSrcA_o    = 2'b10;
            ALUControl_o = 3'b001;
            if (funct3_i == 3'b000) begin
               PCWrite_o = zero_i;
               state_d   = S_FETCH;
            end else if (funct3_i == 3'b001 && SUPPORT_BNE != 0) begin
               PCWrite_o = !zero_i;
               state_d   = S_FETCH;
            end else begin
               state_d = S_ERROR;
            end
         end
         S_JAL: begin
            ALUSrcA_o = 2'b01;
            ALUSrcB_o = 2'b10;
            PCWrite_o = 1'b1;
            state_d   = S_ALUWB;
         end
         S_LUI: begin
            ImmSrc_o    = 3'b100;
            ResultSrc_o = 2'b11;
            RegWrite_o  = 1'b1;
            state_d     = S_FETCH;
         end
         S_ERROR: state_d = S_ERROR;
         default: state_d = S_ERROR;
      endcase
      // Counter only runs while parked in a wait state; any transition clears it.
      cnt_d = '0;
      if (wait_st && !mem_ready_i && state_d == state_q)
         cnt_d = cnt_q + CNT_W'(1);
      if (!reset_n) begin
         PCWrite_o  = 1'b0;
         MemWrite_o = 1'b0;
         IRWrite_o  = 1'b0;
         RegWrite_o = 1'b0;
      end
   end

   assign error_o = (state_q == S_ERROR);
   assign state_o = state_q;

`ifdef UCSBECE154A_CTRL_INSTRET_EN
   logic [31:0] instret_q, instret_d;

   // Count instructions completing back into FETCH.
   always_comb begin
      instret_d = instret_q;
      if (state_d == S_FETCH &&
          (state_q == S_MEMWB || state_q == S_MEMWRITE || state_q == S_ALUWB ||
           state_q == S_BRANCH || state_q == S_LUI))
         instret_d = instret_q + 32'd1;
   end

   // Retired-instruction register.
   always_ff @(posedge clk) begin
      if (!reset_n) instret_q <= '0;
      else          instret_q <= instret_d;
   end

   assign instret_o = instret_q;
`endif

endmodule

// File: tb/tb_ucsbece154a_controller_mc.sv
// Directed bench for ucsbece154a_controller_mc; a second instance is built
// with bne support disabled to exercise the illegal-bne path.
module tb_ucsbece154a_controller_mc;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [6:0] op;
   logic [2:0] f3;
   logic       f7, zero, rdy;
   logic       pcw, adrs, memw, irw, regw, err;
   logic [1:0] ress, asa, asb;
   logic [2:0] imm, aluc;
   logic [3:0] st;
   logic       pcw2, adrs2, memw2, irw2, regw2, err2;
   logic [1:0] ress2, asa2, asb2;
   logic [2:0] imm2, aluc2;
   logic [3:0] st2;
`ifdef UCSBECE154A_CTRL_INSTRET_EN
   logic [31:0] instret, instret2;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   ucsbece154a_controller_mc dut (
      .clk(clk), .reset_n(reset_n), .op_i(op), .funct3_i(f3), .funct7b5_i(f7),
      .zero_i(zero), .mem_ready_i(rdy), .PCWrite_o(pcw), .AdrSrc_o(adrs),
      .MemWrite_o(memw), .IRWrite_o(irw), .RegWrite_o(regw), .ResultSrc_o(ress),
      .ALUSrcA_o(asa), .ALUSrcB_o(asb), .ImmSrc_o(imm), .ALUControl_o(aluc),
      .error_o(err), .state_o(st)
`ifdef UCSBECE154A_CTRL_INSTRET_EN
      , .instret_o(instret)
`endif
   );

   ucsbece154a_controller_mc #(.SUPPORT_BNE(0)) dut_nobne (
      .clk(clk), .reset_n(reset_n), .op_i(op), .funct3_i(f3), .funct7b5_i(f7),
      .zero_i(zero), .mem_ready_i(rdy), .PCWrite_o(pcw2), .AdrSrc_o(adrs2),
      .MemWrite_o(memw2), .IRWrite_o(irw2), .RegWrite_o(regw2), .ResultSrc_o(ress2),
      .ALUSrcA_o(asa2), .ALUSrcB_o(asb2), .ImmSrc_o(imm2), .ALUControl_o(aluc2),
      .error_o(err2), .state_o(st2)
`ifdef UCSBECE154A_CTRL_INSTRET_EN
      , .instret_o(instret2)
`endif
   );

   task automatic test_reset;
      reset_n = 1'b0; rdy = 1'b1; op = 7'b0000011; f3 = 3'b010; f7 = 1'b0; zero = 1'b0;
      @(negedge clk); @(negedge clk); #1;
      total++; if (st !== 4'd0) begin $display("FAIL reset_state got=%0d exp=0", st); bad++; end
      total++; if (err !== 1'b0) begin $display("FAIL reset_err got=%b exp=0", err); bad++; end
      total++; if (pcw !== 1'b0 || irw !== 1'b0) begin
         $display("FAIL reset_strobes got pcw=%b irw=%b exp=0", pcw, irw); bad++; end
`ifdef UCSBECE154A_CTRL_INSTRET_EN
      total++; if (instret !== 32'd0) begin $display("FAIL reset_instret got=%0d exp=0", instret); bad++; end
`endif
      reset_n = 1'b1;
   endtask

   task automatic test_lw;
      logic [3:0] es [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
      op = 7'b0000011; f3 = 3'b010; rdy = 1'b1;
      for (int i = 0; i < 6; i++) begin
         #1;
         total++; if (st !== es[i]) begin $display("FAIL lw_state[%0d] got=%0d exp=%0d", i, st, es[i]); bad++; end
         total++; if (regw !== (es[i] == 4'd4)) begin
            $display("FAIL lw_regwrite[%0d] got=%b exp=%b", i, regw, es[i] == 4'd4); bad++; end
         total++; if ((ress == 2'b01) !== (es[i] == 4'd4)) begin
            $display("FAIL lw_resultsrc[%0d] got=%b", i, ress); bad++; end
         if (i == 0) begin
            total++; if (irw !== 1'b1 || pcw !== 1'b1) begin
               $display("FAIL lw_fetch_en got irw=%b pcw=%b exp=1", irw, pcw); bad++; end
         end
         if (i == 3) begin
            total++; if (adrs !== 1'b1) begin $display("FAIL lw_adrsrc got=%b exp=1", adrs); bad++; end
         end
`ifdef UCSBECE154A_CTRL_INSTRET_EN
         if (i == 5) begin
            total++; if (instret !== 32'd1) begin $display("FAIL lw_instret got=%0d exp=1", instret); bad++; end
         end
`endif
         if (i < 5) @(negedge clk);
      end
   endtask

   task automatic test_sw_wait;
      logic [3:0] es [8] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5, 4'd5, 4'd0};
      logic       rd [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      int nwr = 0;
      op = 7'b0100011; f3 = 3'b010;
      for (int i = 0; i < 8; i++) begin
         rdy = rd[i];
         #1;
         total++; if (st !== es[i]) begin $display("FAIL sw_state[%0d] got=%0d exp=%0d", i, st, es[i]); bad++; end
         total++; if (memw !== (es[i] == 4'd5)) begin
            $display("FAIL sw_memwrite[%0d] got=%b exp=%b", i, memw, es[i] == 4'd5); bad++; end
         if (es[i] == 4'd2) begin
            total++; if (imm !== 3'b001) begin $display("FAIL sw_immsrc got=%b exp=001", imm); bad++; end
         end
         if (memw === 1'b1) nwr++;
         if (i < 7) @(negedge clk);
      end
      total++; if (nwr != 4) begin $display("FAIL sw_memwrite_cycles got=%0d exp=4", nwr); bad++; end
      rdy = 1'b1;
   endtask

   task automatic test_branch;
      logic [3:0] es [4] = '{4'd0, 4'd1, 4'd9, 4'd0};
      op = 7'b1100011; f3 = 3'b000; zero = 1'b1; rdy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         total++; if (st !== es[i]) begin $display("FAIL beq_state[%0d] got=%0d exp=%0d", i, st, es[i]); bad++; end
         if (i == 2) begin
            total++; if (pcw !== 1'b1) begin $display("FAIL beq_pcwrite got=%b exp=1", pcw); bad++; end
            total++; if (aluc !== 3'b001) begin $display("FAIL beq_aluctl got=%b exp=001", aluc); bad++; end
         end
         if (i < 3) @(negedge clk);
      end
      f3 = 3'b001;
      for (int i = 0; i < 4; i++) begin
         #1;
         total++; if (st !== es[i]) begin $display("FAIL bne_state[%0d] got=%0d exp=%0d", i, st, es[i]); bad++; end
         if (i == 2) begin
            total++; if (pcw !== 1'b0) begin $display("FAIL bne_pcwrite got=%b exp=0", pcw); bad++; end
            total++; if (st2 !== 4'd9) begin $display("FAIL nobne_branch got=%0d exp=9", st2); bad++; end
         end
         if (i == 3) begin
            total++; if (st2 !== 4'd12 || err2 !== 1'b1) begin
               $display("FAIL nobne_error got st=%0d err=%b exp st=12 err=1", st2, err2); bad++; end
         end
         if (i < 3) @(negedge clk);
      end
      reset_n = 1'b0;
      #1;
      total++; if (pcw !== 1'b0 || irw !== 1'b0) begin
         $display("FAIL reset_forces_strobes got pcw=%b irw=%b exp=0", pcw, irw); bad++; end
      @(negedge clk); #1;
      total++; if (st2 !== 4'd0 || err2 !== 1'b0) begin
         $display("FAIL nobne_reset got st=%0d err=%b exp st=0 err=0", st2, err2); bad++; end
      reset_n = 1'b1;
      zero = 1'b0;
   endtask

   task automatic test_alu;
      logic [3:0] er [5] = '{4'd0, 4'd1, 4'd6, 4'd8, 4'd0};
      logic [3:0] ei [5] = '{4'd0, 4'd1, 4'd7, 4'd8, 4'd0};
      op = 7'b0110011; f3 = 3'b000; f7 = 1'b1; rdy = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         total++; if (st !== er[i]) begin $display("FAIL rsub_state[%0d] got=%0d exp=%0d", i, st, er[i]); bad++; end
         if (i == 2) begin
            total++; if (aluc !== 3'b001 || asa !== 2'b10 || asb !== 2'b00) begin
               $display("FAIL rsub_ctl got alu=%b a=%b b=%b exp 001/10/00", aluc, asa, asb); bad++; end
         end
         if (i == 3) begin
            total++; if (regw !== 1'b1 || ress !== 2'b00) begin
               $display("FAIL rsub_wb got regw=%b res=%b exp 1/00", regw, ress); bad++; end
         end
         if (i < 4) @(negedge clk);
      end
      op = 7'b0010011;
      for (int i = 0; i < 5; i++) begin
         #1;
         total++; if (st !== ei[i]) begin $display("FAIL addi_state[%0d] got=%0d exp=%0d", i, st, ei[i]); bad++; end
         if (i == 2) begin
            total++; if (aluc !== 3'b000 || asb !== 2'b01 || imm !== 3'b000) begin
               $display("FAIL addi_ctl got alu=%b b=%b imm=%b exp 000/01/000", aluc, asb, imm); bad++; end
         end
         if (i < 4) @(negedge clk);
      end
      f7 = 1'b0;
   endtask

   task automatic test_jal_lui;
      logic [3:0] ej [5] = '{4'd0, 4'd1, 4'd10, 4'd8, 4'd0};
      logic [3:0] el [4] = '{4'd0, 4'd1, 4'd11, 4'd0};
      op = 7'b1101111; rdy = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         total++; if (st !== ej[i]) begin $display("FAIL jal_state[%0d] got=%0d exp=%0d", i, st, ej[i]); bad++; end
         if (i == 2) begin
            total++; if (pcw !== 1'b1 || asa !== 2'b01 || asb !== 2'b10) begin
               $display("FAIL jal_ctl got pcw=%b a=%b b=%b exp 1/01/10", pcw, asa, asb); bad++; end
         end
         if (i < 4) @(negedge clk);
      end
      op = 7'b0110111;
      for (int i = 0; i < 4; i++) begin
         #1;
         total++; if (st !== el[i]) begin $display("FAIL lui_state[%0d] got=%0d exp=%0d", i, st, el[i]); bad++; end
         if (i == 2) begin
            total++; if (ress !== 2'b11 || imm !== 3'b100 || regw !== 1'b1) begin
               $display("FAIL lui_ctl got res=%b imm=%b regw=%b exp 11/100/1", ress, imm, regw); bad++; end
         end
         if (i < 3) @(negedge clk);
      end
   endtask

   task automatic test_reset_midwrite;
      logic [3:0] es [4] = '{4'd0, 4'd1, 4'd2, 4'd5};
      op = 7'b0100011; f3 = 3'b010; rdy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (i == 3) rdy = 1'b0;
         #1;
         total++; if (st !== es[i]) begin $display("FAIL midwr_state[%0d] got=%0d exp=%0d", i, st, es[i]); bad++; end
         if (i < 3) @(negedge clk);
      end
      total++; if (memw !== 1'b1) begin $display("FAIL midwr_memwrite got=%b exp=1", memw); bad++; end
      reset_n = 1'b0;
      #1;
      total++; if (memw !== 1'b0) begin $display("FAIL midwr_drop got=%b exp=0", memw); bad++; end
      @(negedge clk); #1;
      total++; if (st !== 4'd0) begin $display("FAIL midwr_fetch got=%0d exp=0", st); bad++; end
      reset_n = 1'b1; rdy = 1'b1;
   endtask

   task automatic test_illegal;
      op = 7'b1111111; rdy = 1'b1;
      @(negedge clk); @(negedge clk); #1;
      total++; if (st !== 4'd12 || err !== 1'b1) begin
         $display("FAIL illegal_op got st=%0d err=%b exp st=12 err=1", st, err); bad++; end
      op = 7'b0000011;
      repeat (3) @(negedge clk);
      #1;
      total++; if (st !== 4'd12 || pcw !== 1'b0 || irw !== 1'b0) begin
         $display("FAIL illegal_sticky got st=%0d pcw=%b irw=%b exp 12/0/0", st, pcw, irw); bad++; end
      reset_n = 1'b0;
      @(negedge clk); #1;
      reset_n = 1'b1;
   endtask

   task automatic test_timeout;
      int early = 0;
      rdy = 1'b0; op = 7'b0000011;
      for (int k = 0; k < 15; k++) begin
         #1;
         if (st !== 4'd0) early++;
         @(negedge clk);
      end
      total++; if (early != 0) begin $display("FAIL timeout_early got=%0d non-fetch cycles exp=0", early); bad++; end
      #1;
      total++; if (st !== 4'd12 || err !== 1'b1) begin
         $display("FAIL timeout_error got st=%0d err=%b exp st=12 err=1", st, err); bad++; end
      rdy = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      total++; if (err !== 1'b1) begin $display("FAIL timeout_sticky got=%b exp=1", err); bad++; end
      reset_n = 1'b0;
      @(negedge clk); #1;
      total++; if (st !== 4'd0 || err !== 1'b0) begin
         $display("FAIL timeout_reset got st=%0d err=%b exp st=0 err=0", st, err); bad++; end
      reset_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired at time %0t", $time);
      $fatal(1);
   end

   initial begin
      test_reset;
      test_lw;
      test_sw_wait;
      test_branch;
      test_alu;
      test_jal_lui;
      test_reset_midwrite;
      test_illegal;
      test_timeout;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
